imul_int_mul_var: RTL
=====================

Name: imul_int_mul_var

Overview:
- Parametrised, variable-latency iterative integer multiplier with val/rdy request and response interfaces.
- Supports four RISC-V-style modes: MUL (low half), MULH, MULHSU and MULHU (high halves).
- Uses sign-magnitude shift-and-add on a 2*NBITS accumulator, with optional early exit once the remaining multiplier bits are zero.
- Sits in the lab1_imul family as the successor to the fixed 32-cycle base multiplier.

Parameters:
- NBITS, 32, operand and result width; legal range 4..64.
- EARLY_EXIT, 1, when 1 iteration stops once the shifted |b| is zero; when 0 always NBITS iterations.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_val  input  1  request valid
- req_rdy  output  1  request ready
- req_msg  input  2*NBITS  operand a in [2*NBITS-1:NBITS], operand b in [NBITS-1:0]
- req_mode  input  2  0=MUL, 1=MULH (s×s), 2=MULHSU (a signed, b unsigned), 3=MULHU (u×u)
- resp_val  output  1  response valid
- resp_rdy  input  1  response ready
- resp_msg  output  NBITS  result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; a_reg, b_reg, acc, count, neg, mode_reg all cleared.
  - req_rdy=0 and resp_val=0 while reset is high; resp_msg=0 after reset.
  - Reset asserted in any state aborts the operation silently; req_rdy=1 on the first cycle after reset deasserts.
- States: IDLE, CALC, SIGN, DONE.
- IDLE: req_rdy=1.
  - On req_go (req_val & req_rdy), load:
    - a_reg = zero-extended |a|; a is treated as signed for MULH/MULHSU.
    - b_reg = |b|; b is treated as signed for MULH only.
    - acc = 0, count = 0, mode_reg = req_mode.
    - neg = sign(a) XOR sign(b), using the signedness of each operand; neg is forced to 0 for MUL and MULHU.
  - Next state is CALC.
- Magnitude of the most-negative value (-2^(NBITS-1)) is 2^(NBITS-1); it fits unsigned in NBITS bits and needs no special case.
- CALC, one iteration per cycle:
  - if b_reg[0]=1, acc += a_reg (mod 2^(2*NBITS));
  - a_reg <<= 1; b_reg >>= 1; count++.
  - Go to SIGN when count==NBITS-1, or when EARLY_EXIT=1 and (b_reg>>1)==0. Otherwise stay in CALC.
  - CALC therefore lasts k cycles:
    - EARLY_EXIT=1: k = max(1, index of MSB of |b| + 1);
    - EARLY_EXIT=0: k = NBITS.
- SIGN: if neg, acc = -acc (2's complement, 2*NBITS bits). Always exactly 1 cycle, then go to DONE.
- DONE: resp_val=1.
  - resp_msg = acc[NBITS-1:0] for MUL, otherwise acc[2*NBITS-1:NBITS].
  - Hold state, resp_msg and resp_val stable until resp_go; then go to IDLE.
  - req_rdy=0 in DONE: no same-cycle turnaround. Next accept is possible one cycle after resp_go.
- Latency: request accepted at cycle t → resp_val first high at cycle t+k+2. Range is 3..NBITS+2.
- resp_msg is driven from registers only; there is no combinational path from req_* to resp_*.
- req_rdy and resp_val are Moore outputs of state only. resp_rdy never affects req_rdy within the same cycle.
- Inputs are ignored in CALC/SIGN/DONE; req_msg may change freely once accepted.

Decomposition:
- Package imul_pkg holds:
  - mode enum MUL/MULH/MULHSU/MULHU (2 bits);
  - state enum IDLE/CALC/SIGN/DONE (2 bits).
- One sub-module, imul_int_mul_var_dpath:
  - registers a_reg, b_reg, acc, neg;
  - magnitude/negate logic and result half-select;
  - outputs b_rest_zero and b_lsb status to the control.
- Control FSM and count live in the top module.

Test Plan (NBITS=32, EARLY_EXIT=1 unless noted):
- MUL a=3, b=4 → resp_msg 0x0000000C; k=3, so resp_val first high 5 cycles after accept.
- MULH a=0xFFFFFFFF, b=0x00000002 → 0xFFFFFFFF. MULH a=0x80000000, b=0x80000000 → 0x40000000 (k=32, latency 34).
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0x80000000, b=0x00000002 → 0xFFFFFFFF. Same MULHU case with EARLY_EXIT=0 gives an identical result at latency 34.
- MUL a=0x12345678, b=0 → 0x00000000 at latency 3. Back-to-back requests with resp_rdy=1 → req_rdy rises the cycle after each resp_go, and no request is lost.
- Backpressure: resp_rdy=0 for 5 cycles in DONE → resp_val and resp_msg held stable and req_rdy=0 throughout; release gives exactly one response.
- Reset pulsed mid-CALC → no response is produced; req_rdy=1 and busy=0 the cycle after reset drops; the next MUL 7×6 returns 0x0000002A.

Source files
------------

// File: rtl/imul_int_mul_var_pkg.sv
// Shared types for the variable-latency iterative multiplier.
package imul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/imul_int_mul_var_if.sv
// Request/response val/rdy bundle for the iterative multiplier.
interface imul_int_mul_var_if #(
    parameter int unsigned NBITS = 32
);
    logic                 req_val;
    logic                 req_rdy;
    logic [2*NBITS-1:0]   req_msg;
    logic [1:0]           req_mode;
    logic                 resp_val;
    logic                 resp_rdy;
    logic [NBITS-1:0]     resp_msg;

    modport master (
        output req_val, req_msg, req_mode, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, req_mode, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );
endinterface

// File: rtl/imul_int_mul_var_dpath.sv
// Sign-magnitude shift-and-add datapath: operand magnitudes, accumulator, final negate and half-select.
module imul_int_mul_var_dpath
    import imul_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              calc_en,
    input  logic              add_en,
    input  logic              sign_en,
    input  logic [NBITS-1:0]  a_in,
    input  logic [NBITS-1:0]  b_in,
    input  mode_e             mode_in,
    input  mode_e             mode_reg,
    output logic              b_rest_zero,
    output logic              b_lsb,
    output logic [NBITS-1:0]  result
);
    logic [2*NBITS-1:0] a_reg;
    logic [NBITS-1:0]   b_reg;
    logic [2*NBITS-1:0] acc;
    logic               neg;

    logic               a_neg;
    logic               b_neg;
    logic [NBITS-1:0]   a_mag;
    logic [NBITS-1:0]   b_mag;

    // -2^(NBITS-1) negates to 2^(NBITS-1), which is exact as an unsigned magnitude.
    always_comb begin
        a_neg = ((mode_in == MULH) || (mode_in == MULHSU)) && a_in[NBITS-1];
        b_neg = (mode_in == MULH) && b_in[NBITS-1];
        a_mag = a_neg ? (~a_in + 1'b1) : a_in;
        b_mag = b_neg ? (~b_in + 1'b1) : b_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            a_reg <= {{NBITS{1'b0}}, a_mag};
            b_reg <= b_mag;
            acc   <= '0;
            neg   <= a_neg ^ b_neg;
        end else if (calc_en) begin
            if (add_en) begin
                acc <= acc + a_reg;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
        end else if (sign_en && neg) begin
            acc <= ~acc + 1'b1;
        end
    end

    always_comb begin
        b_rest_zero = (b_reg[NBITS-1:1] == '0);
        b_lsb       = b_reg[0];
        result      = (mode_reg == MUL) ? acc[NBITS-1:0] : acc[2*NBITS-1:NBITS];
    end
endmodule

// File: rtl/imul_int_mul_var.sv
// Variable-latency iterative integer multiplier (MUL/MULH/MULHSU/MULHU) with val/rdy handshakes.
module imul_int_mul_var
    import imul_pkg::*;
#(
    parameter int unsigned NBITS      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    imul_int_mul_var_if.slave       io,
    output logic                    busy
);
    localparam int unsigned CW = $clog2(NBITS);

    state_e          state;
    state_e          state_nxt;
    logic [CW-1:0]   count;
    mode_e           mode_reg;
    logic            req_go;
    logic            resp_go;
    logic            last_iter;
    logic            b_rest_zero;
    logic            b_lsb;

    assign req_go    = io.req_val & io.req_rdy;
    assign resp_go   = io.resp_val & io.resp_rdy;
    assign last_iter = (count == CW'(NBITS - 1)) || (EARLY_EXIT && b_rest_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            mode_reg <= MUL;
        end else if (req_go) begin
            count    <= '0;
            mode_reg <= mode_e'(io.req_mode);
        end else if (state == CALC) begin
            count    <= count + CW'(1);
        end
    end

    // Handshake outputs depend on state only; reset masks them while it is held.
    always_comb begin
        state_nxt   = state;
        io.req_rdy  = 1'b0;
        io.resp_val = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                io.req_rdy = ~reset;
                if (req_go) state_nxt = CALC;
            end
            CALC: if (last_iter) state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: begin
                io.resp_val = ~reset;
                if (resp_go) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    imul_int_mul_var_dpath #(
        .NBITS(NBITS)
    ) u_dpath (
        .clk         (clk),
        .reset       (reset),
        .load        (req_go),
        .calc_en     (state == CALC),
        .add_en      ((state == CALC) && b_lsb),
        .sign_en     (state == SIGN),
        .a_in        (io.req_msg[2*NBITS-1:NBITS]),
        .b_in        (io.req_msg[NBITS-1:0]),
        .mode_in     (mode_e'(io.req_mode)),
        .mode_reg    (mode_reg),
        .b_rest_zero (b_rest_zero),
        .b_lsb       (b_lsb),
        .result      (io.resp_msg)
    );
endmodule
